// File: rtl/lut_serial_loader.sv
// Run-time programmable K-input LUT: truth table shifted in bit-serially (bit 0 first)
// over a valid/ready port, committed atomically, looked up with a registered output.
// Optional LUT_READBACK_EN adds cfg_rdata, the old table bit at the current load index.
module lut_serial_loader #(
  parameter int K = 4,
  parameter logic [(1<<K)-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
`ifdef LUT_READBACK_EN
  output logic         cfg_rdata,
`endif
  input  logic [K-1:0] x,
  output logic         y
);

  localparam int D = 1 << K;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t         state, state_n;
  logic [K-1:0]   cnt;
  logic [D-1:0]   shadow;
  logic [D-1:0]   tbl;
  logic           accept;

  assign cfg_ready = (state == LOAD);
  assign cfg_done  = (state == COMMIT);
  // a restart pulse outranks a bit presented in the same cycle
  assign accept    = cfg_ready && cfg_valid && !cfg_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_start) state_n = LOAD;
      LOAD:    if (accept && cnt == {K{1'b1}}) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
      tbl    <= INIT;
      y      <= 1'b0;
    end else begin
      y <= tbl[x];
      if (cfg_start && state != COMMIT) begin
        cnt    <= '0;
        shadow <= '0;
      end else if (accept) begin
        shadow[cnt] <= cfg_bit;
        cnt         <= cnt + 1'b1;
      end
      // table swaps only here, so lookups see old contents for the whole load
      if (cfg_done) tbl <= shadow;
    end
  end

`ifdef LUT_READBACK_EN
  assign cfg_rdata = cfg_ready ? tbl[cnt] : 1'b0;
`endif

endmodule

// File: tb/tb_lut_serial_loader.sv
// Directed bench for lut_serial_loader: lookup expectations go through a scoreboard
// queue filled from a reference copy of the table and drained as y is produced.
module tb_lut_serial_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_valid, cfg_bit;
  logic       cfg_ready, cfg_done;
  logic       cfg_rdata;
  logic [3:0] x;
  logic       y;

  int errors = 0;
  int checks = 0;

  logic [15:0] mt;          // reference table
  logic        q[$];        // expected y scoreboard
  int          cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, acc = 0;

  lut_serial_loader #(.K(4), .INIT(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done),
`ifdef LUT_READBACK_EN
    .cfg_rdata(cfg_rdata),
`endif
    .x(x), .y(y)
  );

`ifndef LUT_READBACK_EN
  assign cfg_rdata = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (cfg_done) begin done_cnt++; done_cyc = cyc; end
      if (cfg_start) start_cyc = cyc;
      if (cfg_valid && cfg_ready && !cfg_start) acc++;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs at negedge, push expected y, check it after the edge
  task automatic cycle(input logic st, input logic v, input logic b, input logic [3:0] xv);
    @(negedge clk);
    cfg_start = st; cfg_valid = v; cfg_bit = b; x = xv;
    q.push_back(mt[xv]);
    @(posedge clk); #1;
    chk($sformatf("y x=%0d", xv), {31'd0, y}, {31'd0, q.pop_front()});
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 4'(i));
  endtask

  task automatic send_bits(input logic [15:0] val, input int lo, input int hi,
                           input bit gap, input bit rb);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      cfg_start = 1'b0; cfg_valid = 1'b1; cfg_bit = val[i]; x = 4'($urandom_range(15));
      q.push_back(mt[x]);
      #1;
      if (rb) chk($sformatf("rdata i=%0d", i), {31'd0, cfg_rdata}, {31'd0, mt[i]});
      @(posedge clk); #1;
      chk("y during load", {31'd0, y}, {31'd0, q.pop_front()});
      if (gap) cycle(1'b0, 1'b0, ~val[i], 4'($urandom_range(15)));
    end
    @(negedge clk); cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input logic [15:0] val);
    for (int k = 0; k < 20 && done_cnt == d0; k++) @(posedge clk);
    #1;
    chk("done seen", done_cnt, d0 + 1);
    mt = val;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; x = '0; mt = 16'h0000;
    #12;
    chk("rst ready", {31'd0, cfg_ready}, 0);
    chk("rst done", {31'd0, cfg_done}, 0);
    chk("rst y", {31'd0, y}, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: INIT table, idle outputs
    sweep();
    chk("idle ready", {31'd0, cfg_ready}, 0);

    // 2: back-to-back load of 16'h8000
    d0 = done_cnt;
    cycle(1'b1, 1'b0, 1'b0, 4'hF);
    send_bits(16'h8000, 0, 15, 1'b0, 1'b0);
    wait_done(d0, 16'h8000);
    chk("done latency", done_cyc - start_cyc, 17);
    sweep();
    chk("single done 8000", done_cnt, d0 + 1);

    // 3: gapped load of parity table
    d0 = done_cnt;
    cycle(1'b1, 1'b0, 1'b0, 4'h3);
    acc = 0;
    send_bits(16'h6996, 0, 15, 1'b1, 1'b0);
    wait_done(d0, 16'h6996);
    chk("accepted bits", acc, 16);
    sweep();

    // 4: restart after 7 bits, restart cycle carries a valid bit
    d0 = done_cnt;
    cycle(1'b1, 1'b0, 1'b0, 4'h1);
    send_bits(16'h1234, 0, 6, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 4'h2);
    chk("ready after restart", {31'd0, cfg_ready}, 1);
    send_bits(16'hFFFF, 0, 15, 1'b0, 1'b0);
    wait_done(d0, 16'hFFFF);
    sweep();
    chk("single done ffff", done_cnt, d0 + 1);

    // 5: async reset mid-load
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    send_bits(16'hAAAA, 0, 8, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async ready", {31'd0, cfg_ready}, 0);
    chk("async y", {31'd0, y}, 0);
    chk("async done", {31'd0, cfg_done}, 0);
    mt = 16'h0000;
    @(negedge clk); rst_n = 1'b1;
    sweep();
    chk("idle after rst", {31'd0, cfg_ready}, 0);

`ifdef LUT_READBACK_EN
    // 6: readback of old table while writing a new one
    d0 = done_cnt;
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    send_bits(16'h6996, 0, 15, 1'b0, 1'b0);
    wait_done(d0, 16'h6996);
    chk("rdata idle", {31'd0, cfg_rdata}, 0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    send_bits(16'h0000, 0, 15, 1'b0, 1'b1);
    wait_done(d0 + 1, 16'h0000);
    sweep();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
